// File: rtl/fir_pkg.sv
// Shared FIR definitions: MAC engine state encoding and default datapath sizes,
// also consumed by the coefficient-load FSM so address ranges agree.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_MAC,
    ST_LAST,
    ST_OUT
  } fir_mac_state_t;

  localparam int FIR_NTAPS  = 62;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_ACC_W  = 40;
  localparam int FIR_ADDR_W = 7;

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample/coefficient/output handshake bundle of the FIR MAC engine.
// slave = engine side, master = surrounding load FSM, RAM and sink.
interface fir_mac_engine_if import fir_pkg::*; #(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ADDR_W = FIR_ADDR_W
) ();
  logic                     coef_ready;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     busy;

  modport slave (
    input  coef_ready, in_valid, in_data, coef_data, out_ready,
    output in_ready, coef_addr, out_valid, out_data, busy
  );

  modport master (
    output coef_ready, in_valid, in_data, coef_data, out_ready,
    input  in_ready, coef_addr, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_delay_line.sv
// Circular NTAPS-deep sample history. Read offset k returns the sample written
// k acceptances ago, relative to the current write slot.
module fir_delay_line import fir_pkg::*; #(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int DATA_W = FIR_DATA_W,
  localparam int IW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     adv,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic        [IW-1:0]     k,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [NTAPS];
  logic [IW-1:0] wp;
  logic [IW-1:0] rd_idx;

  // wp + NTAPS may wrap in IW bits, but the final difference is < NTAPS so
  // modular arithmetic still lands on the right slot.
  always_comb rd_idx = (wp >= k) ? wp - k : wp + IW'(NTAPS) - k;

  assign rdata = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else begin
      if (we) mem[wp] <= wdata;
      if (adv) wp <= (wp == IW'(NTAPS - 1)) ? '0 : wp + 1'b1;
    end
  end
endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR MAC: one sample in, NTAPS coefficient reads, one rounded and
// saturated sample out over a valid/ready handshake.
module fir_mac_engine import fir_pkg::*; #(
  parameter int NTAPS     = FIR_NTAPS,
  parameter int DATA_W    = FIR_DATA_W,
  parameter int COEF_W    = FIR_COEF_W,
  parameter int ACC_W     = FIR_ACC_W,
  parameter int ADDR_W    = FIR_ADDR_W,
  parameter int OUT_SHIFT = 15
) (
  input logic              clk,
  input logic              reset,
  fir_mac_engine_if.slave  bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND  = (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  fir_mac_state_t           state;
  logic        [ADDR_W-1:0] k;
  logic signed [DATA_W-1:0] x_reg, tap_x, sat_out, out_data_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_sum, shifted;
  logic                     in_ready_q, out_valid_q, busy_q;
  logic                     accept, last_tap;

  // In READY in_ready is already high, so in_valid alone completes a handshake;
  // it wins over a simultaneous coef_ready drop so an accepted sample is never lost.
  assign accept   = (state == ST_READY) && bus.in_valid;
  assign last_tap = (k == ADDR_W'(NTAPS - 1));

  fir_delay_line #(.NTAPS(NTAPS), .DATA_W(DATA_W)) u_dline (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .adv   (state == ST_LAST),
    .wdata (bus.in_data),
    .k     (k[TAP_W-1:0]),
    .rdata (tap_x)
  );

  // x_reg holds the sample read alongside address k, so it pairs with coef_data
  // arriving one cycle later.
  always_comb begin
    prod    = x_reg * bus.coef_data;
    acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    shifted = (acc_sum + RND) >>> OUT_SHIFT;
    sat_out = shifted[DATA_W-1:0];
    if (shifted > MAXV)      sat_out = MAXV[DATA_W-1:0];
    else if (shifted < MINV) sat_out = MINV[DATA_W-1:0];
  end

  // k doubles as coef_addr; it is cleared when leaving MAC so the address is 0 elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      k           <= '0;
      acc         <= '0;
      x_reg       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.coef_ready) begin
          state      <= ST_READY;
          in_ready_q <= 1'b1;
        end
        ST_READY: if (accept) begin
          state      <= ST_MAC;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          k          <= '0;
          acc        <= '0;
        end else if (!bus.coef_ready) begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
        ST_MAC: begin
          x_reg <= tap_x;
          if (k != '0) acc <= acc_sum;
          if (last_tap) begin
            k     <= '0;
            state <= ST_LAST;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_LAST: begin
          acc         <= acc_sum;
          out_data_q  <= sat_out;
          out_valid_q <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= bus.coef_ready;
          state       <= bus.coef_ready ? ST_READY : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.coef_addr = k;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench: two engines (OUT_SHIFT 0 and 15) in lockstep, shared coefficient table,
// tap-history reference model with scoreboard, directed tables and random traffic.
module tb_fir_mac_engine;
  import fir_pkg::*;
  localparam int NT = 62;

  logic clk = 1'b0, reset = 1'b1, coef_ready = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] h [128];

  always #5 clk = ~clk;

  fir_mac_engine_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(7)) b0 ();
  fir_mac_engine_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(7)) b15 ();

  assign b0.coef_ready  = coef_ready;  assign b15.coef_ready = coef_ready;
  assign b0.in_valid    = in_valid;    assign b15.in_valid   = in_valid;
  assign b0.in_data     = in_data;     assign b15.in_data    = in_data;
  assign b0.out_ready   = out_ready;   assign b15.out_ready  = out_ready;

  always @(posedge clk) begin
    b0.coef_data  <= h[b0.coef_addr];
    b15.coef_data <= h[b15.coef_addr];
  end

  fir_mac_engine #(.NTAPS(NT), .OUT_SHIFT(0))  d0  (.clk(clk), .reset(reset), .bus(b0));
  fir_mac_engine #(.NTAPS(NT), .OUT_SHIFT(15)) d15 (.clk(clk), .reset(reset), .bus(b15));

  int total = 0, bad = 0, cyc = 0, n_out = 0, last0 = 0, last15 = 0;
  longint hist [NT];
  int exp0_q[$], exp15_q[$], acc_t_q[$], log0[$];
  logic pv_valid = 1'b0, pv_ready = 1'b0;
  logic signed [15:0] pv_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++; bad++;
    $display("FAIL %s", name);
  endtask

  // Round-half-up then saturate to 16 bits, straight from the arithmetic rule.
  function automatic int rs(input longint s, input int sh);
    longint r;
    r = (sh > 0) ? s + (longint'(1) << (sh - 1)) : s;
    r = r >>> sh;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  task automatic model_accept(input int x);
    longint sum = 0;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    for (int i = 0; i < NT; i++) sum += longint'(h[i]) * hist[i];
    exp0_q.push_back(rs(sum, 0));
    exp15_q.push_back(rs(sum, 15));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) hist[i] = 0;
    exp0_q.delete(); exp15_q.delete(); acc_t_q.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (b0.in_ready && (b0.out_valid || b0.busy)) fail("in_ready_overlap");
      if (pv_valid && !pv_ready) begin
        chk("hold_valid", b0.out_valid, 1);
        chk("hold_data", b0.out_data, pv_data);
      end
      if (b0.out_valid && !pv_valid) begin
        if (acc_t_q.size() == 0) fail("latency_no_accept");
        else chk("latency", cyc - acc_t_q.pop_front(), 64);
      end
      if (b0.out_valid && out_ready) begin
        n_out++;
        last0 = b0.out_data; last15 = b15.out_data;
        log0.push_back(b0.out_data);
        if (exp0_q.size() == 0) $display("FAIL spurious_output: got %0d expected none", b0.out_data);
        if (exp0_q.size() == 0) begin total++; bad++; end
        else begin
          chk("out_sh0", b0.out_data, exp0_q.pop_front());
          chk("out_sh15", b15.out_data, exp15_q.pop_front());
          chk("valid_sh15", b15.out_valid, 1);
        end
      end
      if (in_valid && b0.in_ready) begin
        model_accept(in_data);
        acc_t_q.push_back(cyc);
      end
    end
    pv_valid = reset ? 1'b0 : b0.out_valid;
    pv_ready = out_ready;
    pv_data  = b0.out_data;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1'b1; model_clear(); tick(); tick(); reset = 1'b0;
  endtask

  task automatic send_sample(input logic signed [15:0] x);
    in_data = x; in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (b0.in_ready) begin tick(); in_valid = 1'b0; return; end
      tick();
    end
    in_valid = 1'b0;
    fail("send_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 800; i++) begin
      if (exp0_q.size() == 0 && !b0.busy && !b0.out_valid) return;
      tick();
    end
    fail("drain_timeout");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, b0.in_ready, 0);
    chk({tag, "_out_valid"}, b0.out_valid, 0);
    chk({tag, "_out_data"}, b0.out_data, 0);
    chk({tag, "_coef_addr"}, b0.coef_addr, 0);
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_sh15_ctl"}, {b15.in_ready, b15.out_valid, b15.busy, b15.coef_addr}, 0);
  endtask

  task automatic impulse_run(input string tag);
    int nmis = 0;
    for (int k = 0; k < 128; k++) h[k] = (k < NT) ? 16'(k + 1) : '0;
    log0.delete();
    send_sample(16'sd1);
    for (int i = 0; i < NT; i++) send_sample(16'sd0);
    wait_drain();
    chk({tag, "_count"}, log0.size(), NT + 1);
    for (int i = 0; i < log0.size(); i++) if (log0[i] != ((i < NT) ? i + 1 : 0)) nmis++;
    chk({tag, "_mismatches"}, nmis, 0);
  endtask

  typedef struct {
    logic signed [15:0] h0, hr, x;
    int n, e0, e15;
    string name;
  } vec_t;
  vec_t vt [7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n0;
    vt[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 2, 32767, 32767, "sat_pos"};
    vt[1] = '{16'h7FFF, 16'h7FFF, 16'h8000, 2, -32768, -32768, "sat_neg"};
    vt[2] = '{16'h4000, 16'h0000, 16'h0001, 1, 16384, 1, "rnd_half"};
    vt[3] = '{16'h4000, 16'h0000, 16'hFFFF, 1, -16384, 0, "rnd_neg_half"};
    vt[4] = '{16'h3FFF, 16'h0000, 16'h0001, 1, 16383, 0, "rnd_below"};
    vt[5] = '{16'h0001, 16'h0001, 16'd100, 3, 300, 0, "dc_small"};
    vt[6] = '{16'hFFFF, 16'h0000, 16'h8000, 1, 32767, 1, "neg_times_neg"};
    for (int k = 0; k < 128; k++) h[k] = '0;
    model_clear();

    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    // gated while coefficients are not loaded
    in_valid = 1'b1; in_data = 16'sd55; cnt = 0;
    repeat (20) begin tick(); if (b0.in_ready || b0.out_valid) cnt++; end
    chk("gate_no_ready", cnt, 0);
    in_valid = 1'b0;
    coef_ready = 1'b1;
    tick();
    chk("ready_after_coef", b0.in_ready, 1);

    foreach (vt[i]) begin
      do_reset();
      for (int k = 0; k < 128; k++) h[k] = (k == 0) ? vt[i].h0 : ((k < NT) ? vt[i].hr : '0);
      repeat (vt[i].n) send_sample(vt[i].x);
      wait_drain();
      chk({vt[i].name, "_sh0"}, last0, vt[i].e0);
      chk({vt[i].name, "_sh15"}, last15, vt[i].e15);
    end

    do_reset();
    impulse_run("impulse");

    // DC feed wraps the history past its last slot
    do_reset();
    for (int k = 0; k < 128; k++) h[k] = (k < NT) ? 16'sd1 : '0;
    log0.delete();
    repeat (130) send_sample(16'sd100);
    wait_drain();
    cnt = 0;
    for (int i = 0; i < log0.size(); i++) if (log0[i] != 100 * ((i + 1 < NT) ? i + 1 : NT)) cnt++;
    chk("dc_count", log0.size(), 130);
    chk("dc_mismatches", cnt, 0);

    // backpressure
    out_ready = 1'b0;
    send_sample(16'sd1234);
    for (int i = 0; i < 200 && !b0.out_valid; i++) tick();
    chk("bp_valid_up", b0.out_valid, 1);
    n0 = n_out; cnt = 0;
    repeat (10) begin tick(); if (b0.in_ready) cnt++; end
    chk("bp_no_xfer", n_out, n0);
    chk("bp_no_in_ready", cnt, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bp_one_xfer", n_out, n0 + 1);
    chk("bp_valid_down", b0.out_valid, 0);

    // coef_ready drop mid-MAC completes the sample then parks in IDLE
    n0 = n_out;
    send_sample(-16'sd500);
    repeat (10) tick();
    coef_ready = 1'b0;
    wait_drain();
    chk("drop_completes", n_out, n0 + 1);
    cnt = 0;
    repeat (5) begin tick(); if (b0.in_ready || b0.busy) cnt++; end
    chk("drop_idle", cnt, 0);
    coef_ready = 1'b1;
    tick();
    chk("drop_rearm", b0.in_ready, 1);

    // reset in the middle of MAC
    repeat (3) send_sample(16'sd7);
    wait_drain();
    send_sample(16'sd9);
    repeat (29) tick();
    chk("mid_mac_busy", b0.busy, 1);
    reset = 1'b1; model_clear();
    tick();
    chk_reset_vals("midreset");
    reset = 1'b0;
    n0 = n_out;
    repeat (100) tick();
    chk("midreset_no_output", n_out, n0);
    impulse_run("impulse_after_reset");

    // random traffic with random backpressure
    do_reset();
    for (int k = 0; k < NT; k++)
      h[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
    begin
      bit done = 1'b0;
      fork
        begin
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_sample(($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin tick(); out_ready = ($urandom_range(0, 3) != 0); end
        end
      join
    end
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
